// File: rtl/serial_add_ctrl.sv
// Purpose : bit-serial adder; one full_add cell evaluates one bit per clock, LSB first.
// Latency : WIDTH+1 cycles from accepted start to done_out; one op per WIDTH+1 cycles.
// Backpressure: start_in is ignored while busy_out is high (no queuing); accepted again in DONE.
//
// Ports (serial_add_ctrl):
//   clk_in, rst_in           clock and synchronous active-high reset
//   start_in                 begin an addition (sampled in IDLE or DONE only)
//   a_in, b_in, c_in         operands and carry-in, captured on the accepting edge
//   busy_out, done_out       RUN indicator and one-cycle result-valid pulse
//   sum_out, carry_out       result registers, updated only on the edge entering DONE

// Single-bit full adder cell reused by the serial sequencer.
module full_add (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic sum_out,
  output logic carry_out
);
  assign sum_out   = a_in ^ b_in ^ c_in;
  assign carry_out = (a_in & b_in) | (c_in & (a_in ^ b_in));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  // Counter must hold 0..WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             cell_sum;
  logic             cell_carry;
  logic             load;
  logic             last_bit;

  full_add u_full_add (
    .a_in      (a_sh[0]),
    .b_in      (b_sh[0]),
    .c_in      (carry_q),
    .sum_out   (cell_sum),
    .carry_out (cell_carry)
  );

  // Next-state and operand-load decode. A start in DONE reloads directly,
  // giving back-to-back operation without an IDLE bubble.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          state_nxt = RUN;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start_in) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working sum fills from the MSB so that after WIDTH shifts bit 0 holds
  // the first (LSB) result bit.
  always_comb begin
    work_nxt            = work >> 1;
    work_nxt[WIDTH-1]   = cell_sum;
    last_bit            = (state == RUN) && (cnt == LAST_BIT);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_sh      <= '0;
      b_sh      <= '0;
      work      <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else if (load) begin
      a_sh    <= a_in;
      b_sh    <= b_in;
      carry_q <= c_in;
      work    <= '0;
      cnt     <= '0;
    end else if (state == RUN) begin
      a_sh    <= a_sh >> 1;
      b_sh    <= b_sh >> 1;
      work    <= work_nxt;
      carry_q <= cell_carry;
      cnt     <= cnt + CW'(1);
      // Result registers publish only on the final bit so they stay stable
      // through DONE, IDLE and any following RUN.
      if (last_bit) begin
        sum_out   <= work_nxt;
        carry_out <= cell_carry;
      end
    end
  end

  assign busy_out = (state == RUN);
  assign done_out = (state == DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       c8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       carry8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       c1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       carry1;

  logic [32:0] sb[$];
  int n_pass;
  int n_total;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk_in    (clk),
    .rst_in    (rst),
    .start_in  (start8),
    .a_in      (a8),
    .b_in      (b8),
    .c_in      (c8),
    .busy_out  (busy8),
    .done_out  (done8),
    .sum_out   (sum8),
    .carry_out (carry8)
  );

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk_in    (clk),
    .rst_in    (rst),
    .start_in  (start1),
    .a_in      (a1),
    .b_in      (b1),
    .c_in      (c1),
    .busy_out  (busy1),
    .done_out  (done1),
    .sum_out   (sum1),
    .carry_out (carry1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [32:0] obs);
    logic [32:0] e;
    check({tag, "/sb_nonempty"}, 33'(sb.size() != 0), 33'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "/result"}, obs, e);
    end
  endtask

  task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8     = a;
    b8     = b;
    c8     = c;
    start8 = 1'b1;
    sb.push_back(33'(a) + 33'(b) + 33'(c));
    tick();
    start8 = 1'b0;
  endtask

  // Waits (bounded) for done8, counting busy cycles seen on the way.
  task automatic wait_done8(input string tag, input int exp_busy);
    int n;
    int g;
    n = 0;
    g = 0;
    while (done8 !== 1'b1 && g < 64) begin
      if (busy8 === 1'b1) n++;
      tick();
      g++;
    end
    check({tag, "/done_seen"}, 33'(done8), 33'd1);
    check({tag, "/busy_cycles"}, 33'(n), 33'(exp_busy));
    check({tag, "/busy_in_done"}, 33'(busy8), 33'd0);
    pop_check(tag, {24'd0, carry8, sum8});
  endtask

  initial begin
    int n_done;
    int n;
    int g;
    logic hold_bad;
    logic [8:0] held;

    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    start8  = 1'b0;
    a8      = 8'h00;
    b8      = 8'h00;
    c8      = 1'b0;
    start1  = 1'b0;
    a1      = 1'b0;
    b1      = 1'b0;
    c1      = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst/busy", 33'(busy8), 33'd0);
    check("rst/done", 33'(done8), 33'd0);
    check("rst/sum", 33'(sum8), 33'd0);
    check("rst/carry", 33'(carry8), 33'd0);
    rst = 1'b0;
    tick();

    // 0x5A + 0x3C
    start8_op(8'h5A, 8'h3C, 1'b0);
    check("t1/busy_after_start", 33'(busy8), 33'd1);
    wait_done8("t1", 8);
    tick();
    check("t1/done_one_cycle", 33'(done8), 33'd0);

    // Carry-out cases
    start8_op(8'hFF, 8'h01, 1'b0);
    wait_done8("t2a", 8);
    tick();
    start8_op(8'hFF, 8'hFF, 1'b1);
    wait_done8("t2b", 8);
    tick();

    // Start and operand changes during RUN are ignored
    start8_op(8'h10, 8'h20, 1'b0);
    tick();
    tick();
    a8     = 8'hAA;
    b8     = 8'h55;
    c8     = 1'b1;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8("t3", 5);
    tick();
    check("t3/no_second_op", 33'(busy8), 33'd0);
    check("t3/no_second_done", 33'(done8), 33'd0);
    check("t3/sum_held", {24'd0, carry8, sum8}, 33'h030);

    // Reset mid-RUN aborts
    start8_op(8'h33, 8'h44, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_front());
    check("t4/busy", 33'(busy8), 33'd0);
    check("t4/done", 33'(done8), 33'd0);
    check("t4/sum", 33'(sum8), 33'd0);
    check("t4/carry", 33'(carry8), 33'd0);
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 === 1'b1 || busy8 === 1'b1) n_done++;
      tick();
    end
    check("t4/no_activity_after_abort", 33'(n_done), 33'd0);
    start8_op(8'h01, 8'h02, 1'b0);
    wait_done8("t4b", 8);
    tick();

    // start_in held high: back-to-back operations every 9 cycles
    held   = 9'h003;
    a8     = 8'h80;
    b8     = 8'h80;
    c8     = 1'b0;
    start8 = 1'b1;
    sb.push_back(33'h100);
    tick();
    for (int k = 0; k < 3; k++) begin
      n        = 0;
      g        = 0;
      hold_bad = 1'b0;
      while (done8 !== 1'b1 && g < 64) begin
        if (busy8 === 1'b1) n++;
        if ({carry8, sum8} !== held) hold_bad = 1'b1;
        tick();
        g++;
      end
      check($sformatf("t5/%0d/busy_cycles", k), 33'(n), 33'd8);
      check($sformatf("t5/%0d/hold", k), 33'(hold_bad), 33'd0);
      check($sformatf("t5/%0d/busy_in_done", k), 33'(busy8), 33'd0);
      pop_check($sformatf("t5/%0d", k), {24'd0, carry8, sum8});
      held = 9'h100;
      if (k < 2) begin
        sb.push_back(33'h100);
      end else begin
        start8 = 1'b0;
      end
      tick();
    end
    check("t5/idle_after", 33'(busy8), 33'd0);

    // WIDTH=1: 1 + 1 + 1
    a1     = 1'b1;
    b1     = 1'b1;
    c1     = 1'b1;
    start1 = 1'b1;
    sb.push_back(33'd3);
    tick();
    start1 = 1'b0;
    check("t6/busy", 33'(busy1), 33'd1);
    check("t6/done_early", 33'(done1), 33'd0);
    tick();
    check("t6/done", 33'(done1), 33'd1);
    check("t6/busy_in_done", 33'(busy1), 33'd0);
    pop_check("t6", {31'd0, carry1, sum1});
    tick();
    check("t6/done_one_cycle", 33'(done1), 33'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
